// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a valid/ready FIFO, with runtime-selectable parity and stop bits.
// Frames are sent back-to-back whenever the FIFO still holds words at the end of a stop bit.
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DATA_BITS-1:0]                in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [1:0]                          parity_mode,
    input  logic                                stop2,
    output logic                                tx,
    output logic                                busy,
    output logic                                tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W        = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PENULT = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 push;
    logic                 pop;

    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_en;
    logic                 parity_bit;
    logic                 stop2_lat;

    logic                 baud_end;
    logic                 last_stop;
    logic                 frame_end;

    // in_ready looks only at the stored count, so a pop on the same edge never frees a full FIFO early
    assign in_ready  = (fifo_count != FULL_COUNT);
    assign push      = in_valid && in_ready;
    assign fifo_head = mem[rd_ptr];

    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign last_stop = !stop2_lat || stop_idx;
    assign frame_end = (state == STOP) && baud_end && last_stop;
    assign pop       = (fifo_count != '0) && ((state == IDLE) || frame_end);

    always_ff @(posedge clk) begin
        if (push && rst_n) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Parity is computed from the whole word at pop time, since the shift register consumes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift      <= '0;
            parity_en  <= 1'b0;
            parity_bit <= 1'b0;
            stop2_lat  <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (pop) begin
                shift      <= fifo_head;
                parity_en  <= parity_mode[0] ^ parity_mode[1];
                parity_bit <= (^fifo_head) ^ (parity_mode == 2'b01);
                stop2_lat  <= stop2;
                state      <= START;
                baud_cnt   <= '0;
                tx         <= 1'b0;
                busy       <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                    START: begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= DATA;
                            tx       <= shift[0];
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
                    DATA: begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            if (bit_idx == BIT_LAST) begin
                                if (parity_en) begin
                                    state <= PARITY;
                                    tx    <= parity_bit;
                                end else begin
                                    state    <= STOP;
                                    stop_idx <= 1'b0;
                                    tx       <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + BIT_W'(1);
                                shift   <= shift >> 1;
                                tx      <= shift[1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
                    PARITY: begin
                        if (baud_end) begin
                            baud_cnt <= '0;
                            state    <= STOP;
                            stop_idx <= 1'b0;
                            tx       <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
                    STOP: begin
                        // tx_done is registered, so it is raised one cycle ahead of the final stop cycle
                        if (last_stop && (baud_cnt == BAUD_PENULT)) begin
                            tx_done <= 1'b1;
                        end
                        if (baud_end) begin
                            baud_cnt <= '0;
                            if (last_stop) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                stop_idx <= 1'b1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: per-cycle comparison against a queue-based model of the line,
// plus directed frame-length, parity, FIFO-full and reset scenarios.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] parity_mode;
    logic       stop2;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLOCK_FREQ (400),
        .BAUD       (100),
        .DATA_BITS  (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .tx          (tx),
        .busy        (busy),
        .tx_done     (tx_done),
        .fifo_count  (fifo_count)
    );

    int checks = 0;
    int errors = 0;
    int busy_count = 0;

    // Model: words waiting in the FIFO, and the {done, tx} value of every line cycle still to come
    logic [7:0] m_fifo [$];
    logic [1:0] m_future [$];
    logic       m_tx = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic appendFrame(input logic [7:0] w, input logic [1:0] pm, input logic s2);
        logic bq [$];
        bq.push_back(1'b0);
        for (int i = 0; i < 8; i++) bq.push_back(w[i]);
        if (pm == 2'b10) bq.push_back(^w);
        if (pm == 2'b01) bq.push_back(~(^w));
        bq.push_back(1'b1);
        if (s2) bq.push_back(1'b1);
        for (int b = 0; b < bq.size(); b++) begin
            for (int c = 0; c < CPB; c++) begin
                m_future.push_back({(b == bq.size() - 1) && (c == CPB - 1), bq[b]});
            end
        end
    endtask

    task automatic modelEdge();
        logic [1:0] nxt;
        bit do_pop;
        bit do_push;
        if (!rst_n) begin
            m_fifo.delete();
            m_future.delete();
            m_tx = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
            return;
        end
        do_pop  = (m_fifo.size() > 0) && (!m_busy || m_done);
        do_push = in_valid && (m_fifo.size() < DEPTH);
        if (do_pop) appendFrame(m_fifo.pop_front(), parity_mode, stop2);
        if (do_push) m_fifo.push_back(in_data);
        if (m_future.size() > 0) begin
            nxt = m_future.pop_front();
            m_tx = nxt[0];
            m_done = nxt[1];
            m_busy = 1'b1;
        end else begin
            m_tx = 1'b1;
            m_done = 1'b0;
            m_busy = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] pm,
                                 input logic s2, input logic rn);
        in_valid = v;
        in_data = d;
        parity_mode = pm;
        stop2 = s2;
        rst_n = rn;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic checkOutput();
        checkOne("tx", tx, m_tx);
        checkOne("busy", busy, m_busy);
        checkOne("tx_done", tx_done, m_done);
        checkOne("fifo_count", fifo_count, m_fifo.size());
        checkOne("in_ready", in_ready, m_fifo.size() < DEPTH);
        if (busy === 1'b1) busy_count++;
    endtask

    task automatic idle(input int n, input logic [1:0] pm, input logic s2);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, pm, s2, 1'b1);
            checkOutput();
        end
    endtask

    task automatic drain(input string tag, input int bound);
        for (int i = 0; i < bound && (m_busy || m_fifo.size() > 0); i++) begin
            applyStimulus(1'b0, 8'h00, parity_mode, stop2, 1'b1);
            checkOutput();
        end
        checkOne({tag, "_drained"}, busy, 1'b0);
    endtask

    task automatic directedFrame(input string tag, input logic [7:0] w, input logic [1:0] pm,
                                 input logic s2, input int exp_len, input int probe_cycle,
                                 input logic probe_val);
        int nbusy = 0;
        int done_at = -1;
        logic probed = 1'bx;
        applyStimulus(1'b1, w, pm, s2, 1'b1);
        checkOutput();
        for (int c = 1; c <= exp_len + 4; c++) begin
            applyStimulus(1'b0, 8'h00, pm, s2, 1'b1);
            checkOutput();
            if (busy === 1'b1) nbusy++;
            if (tx_done === 1'b1) done_at = c;
            if (c == probe_cycle) probed = tx;
        end
        checkOne({tag, "_busy_len"}, nbusy, exp_len);
        checkOne({tag, "_done_at"}, done_at, exp_len);
        checkOne({tag, "_probe"}, probed, probe_val);
    endtask

    initial begin
        logic [1:0] rpm;
        logic       rs2;

        $display("[TB] reset");
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
        checkOutput();
        idle(3, 2'b00, 1'b0);

        $display("[TB] directed frames");
        directedFrame("f55", 8'h55, 2'b00, 1'b0, 40, 5, 1'b1);
        directedFrame("f07_even", 8'h07, 2'b10, 1'b0, 44, 37, 1'b1);
        directedFrame("f07_odd", 8'h07, 2'b01, 1'b0, 44, 37, 1'b0);
        directedFrame("f07_stop2", 8'h07, 2'b00, 1'b1, 44, 37, 1'b1);

        $display("[TB] fifo full burst");
        for (int k = 1; k <= 50; k++) begin
            applyStimulus(1'b1, 8'($urandom), 2'b00, 1'b0, 1'b1);
            checkOutput();
            if (k == 5) begin
                checkOne("burst_count4", fifo_count, 3'd4);
                checkOne("burst_full", in_ready, 1'b0);
            end
            if (k == 41) checkOne("burst_still_full", in_ready, 1'b0);
            if (k == 42) checkOne("burst_ready_back", in_ready, 1'b1);
        end
        drain("burst", 1000);

        $display("[TB] mid-frame parity change");
        busy_count = 0;
        applyStimulus(1'b1, 8'h3C, 2'b00, 1'b0, 1'b1);
        checkOutput();
        applyStimulus(1'b1, 8'hA1, 2'b00, 1'b0, 1'b1);
        checkOutput();
        idle(14, 2'b00, 1'b0);
        idle(10, 2'b10, 1'b0);
        drain("modechg", 200);
        checkOne("modechg_busy_total", busy_count, 84);

        $display("[TB] reset mid-frame");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 8'($urandom), 2'b00, 1'b0, 1'b1);
            checkOutput();
        end
        idle(12, 2'b00, 1'b0);
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
        checkOutput();
        checkOne("rst_tx", tx, 1'b1);
        checkOne("rst_busy", busy, 1'b0);
        checkOne("rst_count", fifo_count, 3'd0);
        busy_count = 0;
        idle(60, 2'b00, 1'b0);
        checkOne("post_rst_busy", busy_count, 0);

        $display("[TB] random traffic");
        rpm = 2'b00;
        rs2 = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 39) == 0) rpm = 2'($urandom);
            if ($urandom_range(0, 59) == 0) rs2 = 1'($urandom);
            applyStimulus($urandom_range(0, 3) == 0, 8'($urandom), rpm, rs2, 1'b1);
            checkOutput();
        end
        drain("random", 1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
